// File: rtl/alu_issue_pkg.sv
// Shared constants, state encoding and decode helpers for the ALU issue front end.
package alu_issue_pkg;

  // ALU op-codes carried in instruction bits [2:0]
  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_RSVD   = 3'b010;
  localparam logic [2:0] OP_MUL    = 3'b011;
  localparam logic [2:0] OP_CMP_0  = 3'b100;
  localparam logic [2:0] OP_CMP_1  = 3'b101;
  localparam logic [2:0] OP_CMP_2  = 3'b110;
  localparam logic [2:0] OP_DIV    = 3'b111;

  // Instruction bit positions and the stored instruction width
  localparam int INSTR_FLOAT_BIT  = 3;
  localparam int INSTR_SIGNED_BIT = 4;
  localparam int INSTR_W          = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Float ops and the reserved op-code never reach the ALU
  function automatic logic isLegalInstr(input logic [INSTR_W-1:0] instr);
    logic legal;
    legal = (instr[INSTR_FLOAT_BIT] == 1'b0) && (instr[2:0] != OP_RSVD);
    return legal;
  endfunction

  // Only divides may report a zero-divide condition
  function automatic logic isDivInstr(input logic [INSTR_W-1:0] instr);
    logic div;
    div = (instr[2:0] == OP_DIV);
    return div;
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Two-entry register FIFO with occupancy output; push when full and pop when
// empty are ignored so the occupancy can never wrap.
module alu_issue_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wrData,
  output logic [W-1:0] rdData,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [2];
  logic         wrPtr_r;
  logic         rdPtr_r;
  logic [1:0]   count_r;
  logic         pushOk_s;
  logic         popOk_s;

  assign pushOk_s = push && (count_r != 2'd2);
  assign popOk_s  = pop && (count_r != 2'd0);
  assign rdData   = mem_r[rdPtr_r];
  assign count    = count_r;

  // Entry storage: written at the write pointer on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= {W{1'b0}};
      mem_r[1] <= {W{1'b0}};
    end else if (pushOk_s) begin
      mem_r[wrPtr_r] <= wrData;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_r <= 1'b0;
      rdPtr_r <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (pushOk_s) begin
        wrPtr_r <= ~wrPtr_r;
      end
      if (popOk_s) begin
        rdPtr_r <= ~rdPtr_r;
      end
      case ({pushOk_s, popOk_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Request/response front end for the combinational integer ALU: queues requests,
// drives registered ALU operands for a settle window, and returns the captured
// result with its tag over a backpressured response channel.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [31:0]      req_instr,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_ze,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [31:0]      alu_instr,
  input  logic [31:0]      alu_s,
  input  logic             alu_ze,
  output logic             busy
);

  localparam int         ENTRY_W  = 32 + 32 + INSTR_W + TAG_W;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  logic [ENTRY_W-1:0] pushData_s;
  logic [ENTRY_W-1:0] headData_s;
  logic [1:0]         fifoCount_s;
  logic               push_s;
  logic               pop_s;
  logic [31:0]        headA_s;
  logic [31:0]        headB_s;
  logic [INSTR_W-1:0] headInstr_s;
  logic [TAG_W-1:0]   headTag_s;
  logic               unusedInstrHi_s;

  state_e             state_r;
  state_e             stateNext_s;
  logic [3:0]         cnt_r;
  logic               loadAlu_s;
  logic               loadErr_s;
  logic               capture_s;
  logic               decCnt_s;

  logic [31:0]        aluA_r;
  logic [31:0]        aluB_r;
  logic [INSTR_W-1:0] aluInstr_r;

  logic               rspValid_r;
  logic [31:0]        rspResult_r;
  logic               rspZe_r;
  logic               rspErr_r;
  logic [TAG_W-1:0]   rspTag_r;

  // Only the low instruction bits carry meaning; the rest are dropped here.
  assign unusedInstrHi_s = ^req_instr[31:INSTR_W];

  // Ready depends on occupancy alone, with no look-ahead on a same-cycle pop.
  assign req_ready  = (fifoCount_s < 2'd2);
  assign push_s     = req_valid && req_ready;
  assign pushData_s = {req_a, req_b, req_instr[INSTR_W-1:0], req_tag};
  assign {headA_s, headB_s, headInstr_s, headTag_s} = headData_s;

  alu_issue_fifo #(
    .W(ENTRY_W)
  ) uFifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push_s),
    .pop    (pop_s),
    .wrData (pushData_s),
    .rdData (headData_s),
    .count  (fifoCount_s)
  );

  // Next-state and datapath control for the IDLE -> SETTLE -> RESP sequence.
  always_comb begin
    stateNext_s = state_r;
    pop_s       = 1'b0;
    loadAlu_s   = 1'b0;
    loadErr_s   = 1'b0;
    capture_s   = 1'b0;
    decCnt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fifoCount_s != 2'd0) begin
          pop_s = 1'b1;
          if (isLegalInstr(headInstr_s)) begin
            loadAlu_s   = 1'b1;
            stateNext_s = ST_SETTLE;
          end else begin
            loadErr_s   = 1'b1;
            stateNext_s = ST_RESP;
          end
        end else begin
          stateNext_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r != 4'd0) begin
          decCnt_s    = 1'b1;
          stateNext_s = ST_SETTLE;
        end else begin
          capture_s   = 1'b1;
          stateNext_s = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          stateNext_s = ST_IDLE;
        end else begin
          stateNext_s = ST_RESP;
        end
      end
      default: begin
        stateNext_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and settle countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= stateNext_s;
      if (loadAlu_s) begin
        cnt_r <= CNT_LOAD;
      end else if (decCnt_s) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // ALU operand/instruction registers: loaded only when a legal request is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluA_r     <= 32'd0;
      aluB_r     <= 32'd0;
      aluInstr_r <= {INSTR_W{1'b0}};
    end else if (loadAlu_s) begin
      aluA_r     <= headA_s;
      aluB_r     <= headB_s;
      aluInstr_r <= headInstr_s;
    end
  end

  // Response registers: error on an illegal pop, ALU result at the end of settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspValid_r  <= 1'b0;
      rspResult_r <= 32'd0;
      rspZe_r     <= 1'b0;
      rspErr_r    <= 1'b0;
      rspTag_r    <= {TAG_W{1'b0}};
    end else begin
      rspValid_r <= (stateNext_s == ST_RESP);
      if (loadErr_s) begin
        rspResult_r <= 32'd0;
        rspZe_r     <= 1'b0;
        rspErr_r    <= 1'b1;
        rspTag_r    <= headTag_s;
      end else if (loadAlu_s) begin
        rspTag_r <= headTag_s;
      end else if (capture_s) begin
        rspResult_r <= alu_s;
        rspZe_r     <= alu_ze && isDivInstr(aluInstr_r);
        rspErr_r    <= 1'b0;
      end
    end
  end

  assign alu_a      = aluA_r;
  assign alu_b      = aluB_r;
  assign alu_instr  = {{(32 - INSTR_W){1'b0}}, aluInstr_r};
  assign rsp_valid  = rspValid_r;
  assign rsp_result = rspResult_r;
  assign rsp_ze     = rspZe_r;
  assign rsp_err    = rspErr_r;
  assign rsp_tag    = rspTag_r;
  assign busy       = (fifoCount_s != 2'd0) || (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, randomized traffic
// against a queue-based reference, and hand-written backpressure/reset sequences.
module tb_alu_issue;

  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0]      result;
    logic             ze;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [4:0]       instr;
    logic [TAG_W-1:0] tag;
    logic             fz;
    logic [31:0]      expResult;
    logic             expZe;
    logic             expErr;
    int               expLat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // SETTLE=2 instance signals
  logic             reqValid, reqReady, rspValid, rspReady, rspZe, rspErr, aluZe, busy;
  logic [31:0]      reqA, reqB, reqInstr, rspResult, aluA, aluB, aluInstr, aluS;
  logic [TAG_W-1:0] reqTag, rspTag;
  logic             forceZe;

  // SETTLE=1 instance signals
  logic             reqValid1, reqReady1, rspValid1, rspReady1, rspZe1, rspErr1, aluZe1, busy1;
  logic [31:0]      reqA1, reqB1, reqInstr1, rspResult1, aluA1, aluB1, aluInstr1, aluS1;
  logic [TAG_W-1:0] reqTag1, rspTag1;

  // Behavioural integer ALU: {ze, result}
  function automatic logic [32:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] instr);
    logic sgn;
    sgn = instr[4];
    case (instr[2:0])
      3'b000: return {1'b0, a + b};
      3'b001: return {1'b0, a - b};
      3'b011: return {1'b0, a * b};
      3'b100: return {1'b0, 31'd0, (sgn ? ($signed(a) < $signed(b)) : (a < b))};
      3'b101: return {1'b0, 31'd0, (sgn ? ($signed(a) <= $signed(b)) : (a <= b))};
      3'b110: return {1'b0, 31'd0, (a == b)};
      3'b111: begin
        if (b == 32'd0) return {1'b1, 32'd0};
        else if (sgn && b == 32'hFFFF_FFFF) return {1'b0, 32'd0 - a};
        else if (sgn) return {1'b0, 32'($signed(a) / $signed(b))};
        else return {1'b0, a / b};
      end
      default: return 33'd0;
    endcase
  endfunction

  // Expected response for a request, straight from the operation rules
  function automatic rsp_t refRsp(input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] instr, input logic [TAG_W-1:0] tag);
    rsp_t r;
    logic [32:0] alu;
    alu = aluRef(a, b, instr);
    r.tag = tag;
    if (instr[3] || instr[2:0] == 3'b010) begin
      r.result = 32'd0; r.ze = 1'b0; r.err = 1'b1;
    end else begin
      r.result = alu[31:0]; r.ze = (instr[2:0] == 3'b111) ? alu[32] : 1'b0; r.err = 1'b0;
    end
    return r;
  endfunction

  assign {aluZe, aluS}   = aluRef(aluA, aluB, aluInstr[4:0]) | {forceZe, 32'd0};
  assign {aluZe1, aluS1} = aluRef(aluA1, aluB1, aluInstr1[4:0]);

  alu_issue #(.TAG_W(TAG_W), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(reqReady),
    .req_a(reqA), .req_b(reqB), .req_instr(reqInstr), .req_tag(reqTag),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_result(rspResult),
    .rsp_ze(rspZe), .rsp_err(rspErr), .rsp_tag(rspTag),
    .alu_a(aluA), .alu_b(aluB), .alu_instr(aluInstr), .alu_s(aluS), .alu_ze(aluZe),
    .busy(busy)
  );

  alu_issue #(.TAG_W(TAG_W), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid1), .req_ready(reqReady1),
    .req_a(reqA1), .req_b(reqB1), .req_instr(reqInstr1), .req_tag(reqTag1),
    .rsp_valid(rspValid1), .rsp_ready(rspReady1), .rsp_result(rspResult1),
    .rsp_ze(rspZe1), .rsp_err(rspErr1), .rsp_tag(rspTag1),
    .alu_a(aluA1), .alu_b(aluB1), .alu_instr(aluInstr1), .alu_s(aluS1), .alu_ze(aluZe1),
    .busy(busy1)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string name);
    check({name, "_rsp"}, {rspValid, rspResult, rspZe, rspErr, rspTag}, '0);
    check({name, "_alu"}, {aluA, aluB, aluInstr}, '0);
    check({name, "_busy_ready"}, {busy, reqReady}, 2'b01);
  endtask

  task automatic waitRsp(input string name);
    int n;
    n = 0;
    while (!rspValid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, rspValid, 1'b1);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [4:0] instr,
                              input int tag, input logic fz, input logic [31:0] res,
                              input logic ze, input logic err, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.instr = instr; v.tag = TAG_W'(tag); v.fz = fz;
    v.expResult = res; v.expZe = ze; v.expErr = err; v.expLat = lat;
    return v;
  endfunction

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    rsp_t sb[$];
    logic [31:0] lastA, lastB;
    logic [4:0]  lastInstr;
    int accepted, cyc, sent, lat;

    total = 0; bad = 0;
    reqValid = 1'b0; reqA = 32'd0; reqB = 32'd0; reqInstr = 32'd0; reqTag = '0;
    rspReady = 1'b0; forceZe = 1'b0;
    reqValid1 = 1'b0; reqA1 = 32'd0; reqB1 = 32'd0; reqInstr1 = 32'd0; reqTag1 = '0;
    rspReady1 = 1'b1;

    vecs[0] = mk(32'd5,         32'd7, 5'h00, 3, 1'b0, 32'd12,        1'b0, 1'b0, 4);
    vecs[1] = mk(32'hFFFF_FFF8, 32'd0, 5'h17, 1, 1'b0, 32'd0,         1'b1, 1'b0, 4);
    vecs[2] = mk(32'd1,         32'd1, 5'h00, 2, 1'b1, 32'd2,         1'b0, 1'b0, 4);
    vecs[3] = mk(32'd5,         32'd7, 5'h02, 4, 1'b0, 32'd0,         1'b0, 1'b1, 2);
    vecs[4] = mk(32'd9,         32'd9, 5'h08, 5, 1'b0, 32'd0,         1'b0, 1'b1, 2);
    vecs[5] = mk(32'd10,        32'd3, 5'h01, 6, 1'b0, 32'd7,         1'b0, 1'b0, 4);
    vecs[6] = mk(32'd6,         32'd7, 5'h03, 7, 1'b0, 32'd42,        1'b0, 1'b0, 4);
    vecs[7] = mk(32'hFFFF_FFEC, 32'd3, 5'h17, 8, 1'b0, 32'hFFFF_FFFA, 1'b0, 1'b0, 4);
    vecs[8] = mk(32'd3,         32'd9, 5'h04, 9, 1'b0, 32'd1,         1'b0, 1'b0, 4);
    vecs[9] = mk(32'hFFFF_FFFF, 32'd1, 5'h14, 10, 1'b0, 32'd1,        1'b0, 1'b0, 4);

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    checkIdle("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    checkIdle("rst_post");

    // Directed vectors, one request at a time into an idle block
    lastA = 32'd0; lastB = 32'd0; lastInstr = 5'd0;
    rspReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      forceZe = vecs[i].fz;
      reqValid = 1'b1; reqA = vecs[i].a; reqB = vecs[i].b;
      reqInstr = {27'd0, vecs[i].instr}; reqTag = vecs[i].tag;
      check("tbl_ready", reqReady, 1'b1);
      @(negedge clk);
      reqValid = 1'b0;
      @(negedge clk);
      if (!vecs[i].expErr) begin
        lastA = vecs[i].a; lastB = vecs[i].b; lastInstr = vecs[i].instr;
      end
      check("tbl_alu", {aluA, aluB, aluInstr}, {lastA, lastB, 27'd0, lastInstr});
      lat = 2;
      while (!rspValid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("tbl_latency", lat, vecs[i].expLat);
      check("tbl_rsp", {rspResult, rspZe, rspErr, rspTag},
            {vecs[i].expResult, vecs[i].expZe, vecs[i].expErr, vecs[i].tag});
      @(negedge clk);
      check("tbl_drop", rspValid, 1'b0);
      forceZe = 1'b0;
    end

    // Randomized traffic with random backpressure against an in-order scoreboard
    accepted = 0; cyc = 0;
    while ((accepted < 40 || sb.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (accepted < 40) begin
        reqValid = ($urandom_range(0, 3) != 0);
        reqA = $urandom;
        reqB = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        reqInstr = 32'($urandom_range(0, 31));
        reqTag = TAG_W'($urandom);
      end else begin
        reqValid = 1'b0;
      end
      rspReady = ($urandom_range(0, 3) != 0);
      #1;
      if (rspValid) begin
        if (sb.size() == 0) begin
          check("rnd_spurious", rspValid, 1'b0);
        end else begin
          check("rnd_rsp", {rspResult, rspZe, rspErr, rspTag}, sb[0]);
          if (rspReady) void'(sb.pop_front());
        end
      end
      if (reqValid && reqReady) begin
        sb.push_back(refRsp(reqA, reqB, reqInstr[4:0], reqTag));
        accepted++;
      end
    end
    reqValid = 1'b0;
    check("rnd_drain", sb.size(), 0);
    rspReady = 1'b1;
    repeat (2) @(negedge clk);

    // Backpressure: three back-to-back requests with the consumer stalled
    rspReady = 1'b0;
    sent = 0; cyc = 0;
    while (sent < 3 && cyc < 20) begin
      reqValid = 1'b1; reqA = 32'd100 + 32'(sent); reqB = 32'(sent);
      reqInstr = 32'd0; reqTag = TAG_W'(sent);
      #1;
      if (reqReady) sent++;
      @(negedge clk);
      cyc++;
    end
    reqValid = 1'b0;
    check("bp_accepted", sent, 3);
    check("bp_ready_low", reqReady, 1'b0);
    waitRsp("bp_first_timeout");
    for (int k = 0; k < 10; k++) begin
      check("bp_hold", {rspValid, rspResult, rspZe, rspErr, rspTag},
            {1'b1, 32'd100, 1'b0, 1'b0, TAG_W'(0)});
      check("bp_full", reqReady, 1'b0);
      @(negedge clk);
    end
    rspReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      waitRsp("bp_drain_timeout");
      check("bp_order", {rspTag, rspResult, rspErr}, {TAG_W'(k), 32'(100 + 2 * k), 1'b0});
      @(negedge clk);
    end
    check("bp_idle", busy, 1'b0);

    // Reset with one op settling and one queued
    reqValid = 1'b1; reqA = 32'd11; reqB = 32'd22; reqInstr = 32'd0; reqTag = TAG_W'(5);
    @(negedge clk);
    reqA = 32'd33; reqB = 32'd44; reqTag = TAG_W'(6);
    @(negedge clk);
    reqValid = 1'b0;
    check("mid_settling", {busy, aluA, rspValid}, {1'b1, 32'd11, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("mid_no_rsp", {rspValid, busy}, 2'b00);
    end

    // SETTLE=1 build: legal op responds at T+3, illegal at T+2
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("s1_ready", reqReady1, 1'b1);
      reqValid1 = 1'b1; reqA1 = 32'd9 + 32'(i); reqB1 = 32'd4;
      reqInstr1 = (i == 0) ? 32'h00 : 32'h0A; reqTag1 = TAG_W'(7 + i);
      @(negedge clk);
      reqValid1 = 1'b0;
      @(negedge clk);
      lat = 2;
      while (!rspValid1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("s1_latency", lat, (i == 0) ? 3 : 2);
      check("s1_rsp", {rspResult1, rspZe1, rspErr1, rspTag1},
            (i == 0) ? {32'd13, 1'b0, 1'b0, TAG_W'(7)} : {32'd0, 1'b0, 1'b1, TAG_W'(8)});
      @(negedge clk);
    end
    check("s1_idle", {busy1, rspValid1}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
